fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences instruction fetch for the IF stage over a request/acknowledge instruction-memory port, replacing a single-cycle array lookup with a handshake that tolerates wait states. Owns the fetch PC and arbitrates next-PC sources: exception entry, ERET return, branch/jump redirect, sequential increment. Presents each fetched instruction, with its PC and fetch exception code, in a one-entry output buffer held until the IF/ID register accepts it.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC after reset
- HANDLER_PC, 32'h0000_4180, exception entry
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_4ffc, highest legal fetch address

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- stall_i  in  1  IF/ID cannot accept this cycle
- br_valid_i  in  1  branch/jump taken in ID; qualified by !stall_i
- br_pc_i  in  32  branch/jump target
- exc_i  in  1  take exception (from CP0)
- eret_i  in  1  ERET committing
- epc_i  in  32  ERET return address
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word address; stable while request is pending
- imem_ack_i  in  1  read complete; data valid this cycle
- imem_rdata_i  in  32  instruction word
- fetch_valid_o  out  1  output buffer holds an instruction
- fetch_pc_o  out  32  PC of buffered instruction
- fetch_instr_o  out  32  buffered instruction
- fetch_exc_o  out  5  0 = none, 4 = AdEL (fetch)

## Operation
- Registers: pc (next fetch address), addr (in-flight address), pend_valid/pend_pc, output buffer, state.
- States: IDLE, REQ, DROP, FULL.
- IDLE (reset state): all outputs low/zero except fetch_pc_o = RESET_PC; next cycle -> REQ.
- REQ: pc legal (word-aligned, TEXT_LO..TEXT_HI inclusive) -> imem_req_o=1, imem_addr_o=addr=pc.
  - ack: buffer <= {pc, rdata, 0}; pc <= br target (if this cycle), else pend_pc if pend_valid, else pc+4; clear pend; -> FULL.
  - no ack, br redirect: pend_valid<=1, pend_pc<=br_pc_i (delay slot still in flight).
  - pc illegal: no request; buffer <= {pc, 32'h0, 4}; -> FULL. PC does not advance.
- FULL: fetch_valid_o=1. !stall_i -> consumed, -> REQ. br redirect -> pc <= br_pc_i.
- DROP: request held at old addr until ack; data discarded; then -> REQ.
- Priority: reset > exc_i > eret_i > br_valid_i > sequential.
  - exc_i/eret_i in any state: pc <= HANDLER_PC / epc_i; clear pend and buffer (fetch_valid_o=0 next cycle).
  - Next state: REQ, if no request outstanding or ack this cycle; DROP, if request outstanding without ack.
  - exc/eret arriving in DROP: retarget pc, remain DROP.
- pc+4 wraps modulo 2^32. A wrapped PC is illegal, so the next fetch raises AdEL.

## Timing
- Request-to-buffer: data captured on the edge where imem_req_o & imem_ack_i; fetch_valid_o high the next cycle.
- Zero-wait memory: one instruction per 2 cycles (REQ, FULL). Each wait state adds one cycle.
- Ack in the first REQ cycle is legal. Ack outside REQ/DROP is ignored.
- Buffer outputs are stable while fetch_valid_o=1 and stall_i=1.
- Reset mid-request: immediate return to IDLE. A late ack after reset release is ignored because IDLE has no request.
- Illegal-PC fault: REQ -> FULL in one cycle, no bus activity.

## Structure
- Shared package: state enum, EXC_NONE=0 and EXC_ADEL=4 constants, default address constants.
- One combinational sub-module, fetch_addr_check: legal = pc[1:0]==0 & TEXT_LO<=pc<=TEXT_HI. Reused by the MEM-stage checker.

## Test plan
- Reset release, ack after 0 and 2 wait cycles -> addr 3000, 3004, 3008. fetch_pc_o matches, fetch_exc_o=0. Minimum 2-cycle spacing.
- stall_i high 3 cycles while FULL -> buffer unchanged, no new request, then resumes at pc+4.
- Branch at 0x3004 (target 0x3100) while delay slot 0x3008 is unacked -> 0x3008 delivered, next request 0x3100.
- exc_i during a wait-stated request at 0x300c -> DROP, returned data discarded, next request 0x4180, fetch_valid_o low until then.
- eret_i with epc_i=0x3002 -> no request, buffer {0x3002, 0, 4}. Same with epc_i=0x5000.
- Simultaneous exc_i, eret_i, br_valid_i -> next request 0x4180, pend cleared.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its address checker.
// Contents: FSM state encodings, fetch exception codes, default address map, output buffer record.
// No logic lives here; importers decide how the constants are used.
package fetch_sequencer_pkg;

  // FSM state encodings
  typedef logic [1:0] fetchState_t;
  localparam fetchState_t ST_IDLE = 2'd0;  // reset state, no request
  localparam fetchState_t ST_REQ  = 2'd1;  // issuing/holding a request for pc
  localparam fetchState_t ST_DROP = 2'd2;  // finishing a request whose data is discarded
  localparam fetchState_t ST_FULL = 2'd3;  // output buffer valid, waiting for IF/ID

  // Fetch exception codes
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Default address map
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI    = 32'h0000_4ffc;

  // One-entry output buffer contents
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } fetchBuf_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of every fetch-sequencer signal except clock and reset.
// master: sequencer side (drives imem request and fetch buffer outputs).
// slave: environment side (pipeline control, CP0, instruction memory).
interface fetch_sequencer_if;

  // pipeline control
  logic        stall_i;
  logic        br_valid_i;
  logic [31:0] br_pc_i;
  logic        exc_i;
  logic        eret_i;
  logic [31:0] epc_i;
  // instruction memory port
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  // output buffer
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_instr_o;
  logic [4:0]  fetch_exc_o;

  modport master (
    input  stall_i, br_valid_i, br_pc_i, exc_i, eret_i, epc_i,
    input  imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output fetch_valid_o, fetch_pc_o, fetch_instr_o, fetch_exc_o
  );

  modport slave (
    output stall_i, br_valid_i, br_pc_i, exc_i, eret_i, epc_i,
    output imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  fetch_valid_o, fetch_pc_o, fetch_instr_o, fetch_exc_o
  );

endinterface

// File: rtl/fetch_addr_check.sv
// Legal-fetch-address check: word aligned and inside [TEXT_LO, TEXT_HI].
// Latency: purely combinational. Backpressure: none.
// Ports: pc (address under test), legal (1 = may be fetched).
module fetch_addr_check
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] TEXT_LO = DEF_TEXT_LO,
  parameter logic [31:0] TEXT_HI = DEF_TEXT_HI
) (
  input  logic [31:0] pc,
  output logic        legal
);

  assign legal = (pc[1:0] == 2'b00) && (pc >= TEXT_LO) && (pc <= TEXT_HI);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, issues req/ack instruction-memory reads, fills a one-entry buffer.
// Latency: buffer valid the cycle after req&ack; zero-wait memory gives one instruction per 2 cycles.
// Backpressure: stall_i holds the buffer unchanged and suppresses new requests until it is accepted.
// Ports: clk, reset (async active-low), fifc (master modport: pipeline control, imem port, buffer outputs).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] TEXT_LO    = DEF_TEXT_LO,
  parameter logic [31:0] TEXT_HI    = DEF_TEXT_HI
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  fifc
);

  fetchState_t state;
  logic [31:0] pc;         // next fetch address
  logic [31:0] addr;       // address of the request currently on the bus
  logic        pendValid;  // redirect seen while the delay-slot fetch was still in flight
  logic [31:0] pendPc;
  fetchBuf_t   bufReg;

  logic        pcLegal;
  logic        reqOut;
  logic        brTake;
  logic        redirect;
  logic [31:0] redirectPc;

  fetch_addr_check #(
    .TEXT_LO (TEXT_LO),
    .TEXT_HI (TEXT_HI)
  ) uAddrCheck (
    .pc    (pc),
    .legal (pcLegal)
  );

  // DROP keeps driving the captured address so the bus sees a stable request
  // even though pc has already been retargeted.
  assign reqOut     = ((state == ST_REQ) && pcLegal) || (state == ST_DROP);
  assign brTake     = fifc.br_valid_i && !fifc.stall_i;
  assign redirect   = fifc.exc_i || fifc.eret_i;
  assign redirectPc = fifc.exc_i ? HANDLER_PC : fifc.epc_i;

  assign fifc.imem_req_o    = reqOut;
  assign fifc.imem_addr_o   = (state == ST_DROP) ? addr :
                              ((state == ST_REQ) && pcLegal) ? pc : 32'h0;
  assign fifc.fetch_valid_o = (state == ST_FULL);
  assign fifc.fetch_pc_o    = bufReg.pc;
  assign fifc.fetch_instr_o = bufReg.instr;
  assign fifc.fetch_exc_o   = bufReg.exc;

  // addr shadows pc during REQ so that a redirect turning REQ into DROP
  // still has the in-flight address available.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= 32'h0;
    end else if (state == ST_REQ) begin
      addr <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      pendValid <= 1'b0;
      pendPc    <= 32'h0;
      bufReg    <= '{pc: RESET_PC, instr: 32'h0, exc: EXC_NONE};
    end else if (redirect) begin
      // Exception/ERET override everything; an outstanding request must still
      // complete on the bus, so its data is swallowed in DROP.
      pc           <= redirectPc;
      pendValid    <= 1'b0;
      bufReg.instr <= 32'h0;
      bufReg.exc   <= EXC_NONE;
      state        <= (reqOut && !fifc.imem_ack_i) ? ST_DROP : ST_REQ;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;

        ST_REQ: begin
          if (!pcLegal) begin
            // Faulting fetch goes straight to the buffer; pc is left in place.
            bufReg <= '{pc: pc, instr: 32'h0, exc: EXC_ADEL};
            if (brTake) pc <= fifc.br_pc_i;
            state <= ST_FULL;
          end else if (fifc.imem_ack_i) begin
            bufReg    <= '{pc: pc, instr: fifc.imem_rdata_i, exc: EXC_NONE};
            pc        <= brTake ? fifc.br_pc_i : (pendValid ? pendPc : pc + 32'd4);
            pendValid <= 1'b0;
            state     <= ST_FULL;
          end else if (brTake) begin
            // Delay slot still in flight: apply the target once it lands.
            pendValid <= 1'b1;
            pendPc    <= fifc.br_pc_i;
          end
        end

        ST_DROP: begin
          if (fifc.imem_ack_i) state <= ST_REQ;
        end

        ST_FULL: begin
          if (!fifc.stall_i) state <= ST_REQ;
          if (brTake) pc <= fifc.br_pc_i;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if ifc ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .fifc  (ifc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } item_t;

  typedef struct {
    int          waitCyc;   // memory wait states for this fetch
    int          stallCyc;  // cycles the buffer is held before acceptance
    logic [31:0] pc;        // expected fetch_pc_o
    logic [4:0]  exc;       // expected fetch_exc_o
    int          gap;       // expected cycles since previous acceptance (-1 = skip)
  } vec_t;

  item_t       expQ[$];
  logic [31:0] expAddr[$];
  logic [31:0] addrLog[$];

  int checks = 0;
  int errors = 0;

  // memory model / stimulus state
  int          memWait = 0;
  int          waitCnt = 0;
  bit          memBusy = 0;
  logic [31:0] lastAddr = '0;
  int          trigKind = 0;  // 1 br, 2 exc, 3 eret, 4 exc+eret+br
  logic [31:0] trigAddr = '0;
  logic [31:0] trigTarget = '0;
  bit          forceStall = 0;
  int          stallLeft = 0;
  int          cycCnt = 0;
  int          lastConsume = 0;
  bit          chkLowNext = 0;
  bit          brNext = 0, excNext = 0, eretNext = 0;
  logic [31:0] brPcNext = '0, epcNext = '0;

  vec_t tbl[5];

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] p, input logic [4:0] e);
    item_t it;
    it.pc    = p;
    it.instr = (e == EXC_NONE) ? instrOf(p) : 32'h0;
    it.exc   = e;
    expQ.push_back(it);
    if (e == EXC_NONE) expAddr.push_back(p);
  endtask

  // One clock: sample outputs at the falling edge, model memory, consume, drive inputs.
  task automatic cycle();
    bit    ack;
    bit    stallNow;
    item_t e;
    @(negedge clk);
    cycCnt++;
    if (chkLowNext) begin
      chkLowNext = 0;
      chk("valid_low_after_exc", 32'(ifc.fetch_valid_o), 32'h0);
    end
    ack = 0;
    if (ifc.imem_req_o) begin
      if (memBusy) chk("addr_stable", ifc.imem_addr_o, lastAddr);
      if (waitCnt >= memWait) begin
        ack = 1; waitCnt = 0; memBusy = 0;
        addrLog.push_back(ifc.imem_addr_o);
      end else begin
        waitCnt++; memBusy = 1; lastAddr = ifc.imem_addr_o;
      end
      if (trigKind != 0 && !ack && ifc.imem_addr_o == trigAddr) begin
        case (trigKind)
          1: begin brNext = 1; brPcNext = trigTarget; end
          2: begin excNext = 1; chkLowNext = 1; end
          3: begin eretNext = 1; epcNext = trigTarget; end
          default: begin
            brNext = 1; brPcNext = trigTarget;
            excNext = 1; eretNext = 1; epcNext = 32'h0000_3500;
          end
        endcase
        trigKind = 0;
      end
    end
    stallNow = forceStall;
    if (ifc.fetch_valid_o && stallLeft > 0) begin
      stallNow = 1;
      stallLeft--;
      chk("stall_no_req", 32'(ifc.imem_req_o), 32'h0);
      if (expQ.size() > 0) begin
        chk("stall_hold_pc", ifc.fetch_pc_o, expQ[0].pc);
        chk("stall_hold_instr", ifc.fetch_instr_o, expQ[0].instr);
      end
    end
    if (ifc.fetch_valid_o && !stallNow) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch: got pc %h, expected no delivery", ifc.fetch_pc_o);
      end else begin
        e = expQ.pop_front();
        chk("fetch_pc", ifc.fetch_pc_o, e.pc);
        chk("fetch_instr", ifc.fetch_instr_o, e.instr);
        chk("fetch_exc", 32'(ifc.fetch_exc_o), 32'(e.exc));
      end
      lastConsume = cycCnt;
    end
    ifc.imem_ack_i   = ack;
    ifc.imem_rdata_i = ack ? instrOf(ifc.imem_addr_o) : 32'hDEAD_BEEF;
    ifc.stall_i      = stallNow;
    ifc.br_valid_i   = brNext;
    ifc.br_pc_i      = brPcNext;
    ifc.exc_i        = excNext;
    ifc.eret_i       = eretNext;
    ifc.epc_i        = epcNext;
    brNext = 0; excNext = 0; eretNext = 0;
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d deliveries pending, required 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkAddrLog();
    checks++;
    if (addrLog.size() != expAddr.size()) begin
      errors++;
      $display("FAIL req_addr_count: got %0d, expected %0d", addrLog.size(), expAddr.size());
    end
    for (int i = 0; i < addrLog.size() && i < expAddr.size(); i++)
      chk("req_addr", addrLog[i], expAddr[i]);
    addrLog.delete();
    expAddr.delete();
  endtask

  task automatic resetDut();
    #2 reset = 1'b0;
    #1;
    chk("rst_req", 32'(ifc.imem_req_o), 32'h0);
    chk("rst_addr", ifc.imem_addr_o, 32'h0);
    chk("rst_valid", 32'(ifc.fetch_valid_o), 32'h0);
    chk("rst_pc", ifc.fetch_pc_o, 32'h0000_3000);
    chk("rst_instr", ifc.fetch_instr_o, 32'h0);
    chk("rst_exc", 32'(ifc.fetch_exc_o), 32'h0);
    checkAddrLog();
    expQ.delete();
    memBusy = 0; waitCnt = 0; trigKind = 0; stallLeft = 0; forceStall = 0;
    ifc.stall_i = 0; ifc.br_valid_i = 0; ifc.br_pc_i = '0;
    ifc.exc_i = 0; ifc.eret_i = 0; ifc.epc_i = '0;
    ifc.imem_ack_i = 0; ifc.imem_rdata_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // stray ack while IDLE must be ignored
    ifc.imem_ack_i   = 1'b1;
    ifc.imem_rdata_i = 32'hBAD0_BAD0;
  endtask

  task automatic holdFirstValid(input string tag);
    int n;
    n = 0;
    while (!ifc.fetch_valid_o && n < 10) begin
      cycle();
      n++;
    end
    chk({tag, "_valid"}, 32'(ifc.fetch_valid_o), 32'h1);
  endtask

  initial begin
    int prev;
    tbl[0] = '{0, 0, 32'h0000_3000, EXC_NONE, -1};
    tbl[1] = '{0, 0, 32'h0000_3004, EXC_NONE, 2};
    tbl[2] = '{2, 0, 32'h0000_3008, EXC_NONE, 4};
    tbl[3] = '{0, 3, 32'h0000_300c, EXC_NONE, 5};
    tbl[4] = '{1, 0, 32'h0000_3010, EXC_NONE, 3};

    reset = 1'b1;
    resetDut();

    // sequential fetch with wait states and stalls
    for (int i = 0; i < 5; i++) begin
      memWait   = tbl[i].waitCyc;
      stallLeft = tbl[i].stallCyc;
      pushExp(tbl[i].pc, tbl[i].exc);
      prev = lastConsume;
      drain(20, "table");
      if (tbl[i].gap >= 0) chk("accept_gap", lastConsume - prev, tbl[i].gap);
    end

    // reset while a request is pending
    memWait = 5;
    cycle();
    chk("req_before_reset", 32'(ifc.imem_req_o), 32'h1);
    resetDut();

    // branch at 0x3004, delay slot 0x3008 still waiting for ack
    memWait = 0;
    pushExp(32'h0000_3000, EXC_NONE);
    pushExp(32'h0000_3004, EXC_NONE);
    drain(20, "br_pre");
    memWait = 2; trigKind = 1; trigAddr = 32'h0000_3008; trigTarget = 32'h0000_3100;
    pushExp(32'h0000_3008, EXC_NONE);
    pushExp(32'h0000_3100, EXC_NONE);
    drain(30, "branch");
    resetDut();

    // exception during a wait-stated request at 0x300c
    memWait = 0;
    pushExp(32'h0000_3000, EXC_NONE);
    pushExp(32'h0000_3004, EXC_NONE);
    pushExp(32'h0000_3008, EXC_NONE);
    drain(30, "exc_pre");
    memWait = 3; trigKind = 2; trigAddr = 32'h0000_300c;
    expAddr.push_back(32'h0000_300c);  // completes on the bus, data dropped
    pushExp(32'h0000_4180, EXC_NONE);
    drain(40, "exc");
    resetDut();

    // ERET to misaligned, last-legal and out-of-range addresses
    memWait = 0;
    expAddr.push_back(32'h0000_3000);
    stallLeft = 100;
    expQ.push_back('{32'h0000_3000, instrOf(32'h0000_3000), EXC_NONE});
    holdFirstValid("eret_hold");
    eretNext = 1; epcNext = 32'h0000_3002;
    cycle();
    stallLeft = 0;
    expQ.delete();
    pushExp(32'h0000_3002, EXC_ADEL);
    drain(20, "eret_3002");
    forceStall = 1;
    eretNext = 1; epcNext = 32'h0000_4ffc;
    cycle();
    forceStall = 0;
    pushExp(32'h0000_4ffc, EXC_NONE);
    pushExp(32'h0000_5000, EXC_ADEL);
    drain(20, "eret_4ffc");
    forceStall = 1;
    eretNext = 1; epcNext = 32'h0000_5000;
    cycle();
    forceStall = 0;
    pushExp(32'h0000_5000, EXC_ADEL);
    drain(20, "eret_5000");
    resetDut();

    // exc, eret and branch together during a wait-stated request
    memWait = 0;
    pushExp(32'h0000_3000, EXC_NONE);
    drain(20, "all_pre");
    memWait = 2; trigKind = 4; trigAddr = 32'h0000_3004; trigTarget = 32'h0000_3100;
    expAddr.push_back(32'h0000_3004);
    pushExp(32'h0000_4180, EXC_NONE);
    pushExp(32'h0000_4184, EXC_NONE);
    drain(40, "all");
    resetDut();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1);
  end

endmodule
